// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the s0/s1/s2 integer datapath: two-entry scoreboard,
// RAW hazard detection on s0 operand reads, s2 memory handshake and stall counters.
module hazard_sequencer #(
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_valid,
  input  logic [4:0]                 s0_rs1,
  input  logic [4:0]                 s0_rs2,
  input  logic                       s0_uses_rs1,
  input  logic                       s0_uses_rs2,
  input  logic [4:0]                 s0_rd,
  input  logic                       s0_writes_rd,
  input  logic                       s0_is_mem,
  input  logic                       mem_ack,
  output logic                       s0_enable,
  output logic                       pipe_enable,
  output logic                       s1_valid,
  output logic                       s2_valid,
  output logic                       mem_req,
  output logic [STALL_CNT_WIDTH-1:0] raw_stall_cnt,
  output logic [STALL_CNT_WIDTH-1:0] mem_stall_cnt
);

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 writes_rd;
    logic                 is_mem;
  } sb_entry_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t    state, state_nxt;
  sb_entry_t s1_q, s2_q, s1_nxt;
  logic      raw_hazard;
  logic      freeze;

  // x0 is hardwired, so it can never be pending.
  function automatic logic is_pending(input sb_entry_t e, input logic [REG_IDX_W-1:0] r);
    return e.valid && e.writes_rd && (e.rd == r) && (r != '0);
  endfunction

  // RAW check against both in-flight entries; no forwarding paths exist.
  always_comb begin
    raw_hazard = s0_valid &&
                 ((s0_uses_rs1 && (is_pending(s1_q, s0_rs1) || is_pending(s2_q, s0_rs1))) ||
                  (s0_uses_rs2 && (is_pending(s1_q, s0_rs2) || is_pending(s2_q, s0_rs2))));
  end

  // Memory handshake FSM and stage clock enables.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    freeze      = 1'b0;
    pipe_enable = 1'b0;
    s0_enable   = 1'b0;
    case (state)
      RUN: begin
        mem_req = s2_q.valid && s2_q.is_mem;
        if (mem_req && !mem_ack) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) mem_req = 1'b0;
    freeze      = mem_req && !mem_ack;
    pipe_enable = !rst && !freeze;
    s0_enable   = pipe_enable && !raw_hazard;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Entry issued into s1: the s0 instruction, or a bubble while it is stalled.
  always_comb begin
    s1_nxt = '0;
    if (s0_valid && !raw_hazard) begin
      s1_nxt.valid     = 1'b1;
      s1_nxt.rd        = s0_rd;
      s1_nxt.writes_rd = s0_writes_rd;
      s1_nxt.is_mem    = s0_is_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (pipe_enable) begin
      s2_q <= s1_q;
      s1_q <= s1_nxt;
    end
  end

  // A frozen cycle is charged to memory even if a RAW hazard is also present.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_stall_cnt <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (freeze && (mem_stall_cnt != CNT_MAX))
        mem_stall_cnt <= mem_stall_cnt + STALL_CNT_WIDTH'(1);
      if (raw_hazard && !freeze && (raw_stall_cnt != CNT_MAX))
        raw_stall_cnt <= raw_stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign s1_valid = s1_q.valid;
  assign s2_valid = s2_q.valid;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed vector table, hand sequences
// and randomized traffic against an instruction-level pipeline model.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst, s0_valid, s0_uses_rs1, s0_uses_rs2, s0_writes_rd, s0_is_mem, mem_ack;
  logic [4:0]  s0_rs1, s0_rs2, s0_rd;
  logic        s0_enable, pipe_enable, s1_valid, s2_valid, mem_req;
  logic [15:0] raw_stall_cnt, mem_stall_cnt;
  logic        w2_s0_enable, w2_pipe_enable, w2_s1_valid, w2_s2_valid, w2_mem_req;
  logic [1:0]  w2_raw_cnt, w2_mem_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .s0_valid(s0_valid), .s0_rs1(s0_rs1), .s0_rs2(s0_rs2),
    .s0_uses_rs1(s0_uses_rs1), .s0_uses_rs2(s0_uses_rs2), .s0_rd(s0_rd),
    .s0_writes_rd(s0_writes_rd), .s0_is_mem(s0_is_mem), .mem_ack(mem_ack),
    .s0_enable(s0_enable), .pipe_enable(pipe_enable), .s1_valid(s1_valid),
    .s2_valid(s2_valid), .mem_req(mem_req), .raw_stall_cnt(raw_stall_cnt),
    .mem_stall_cnt(mem_stall_cnt)
  );

  hazard_sequencer #(.STALL_CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .s0_valid(s0_valid), .s0_rs1(s0_rs1), .s0_rs2(s0_rs2),
    .s0_uses_rs1(s0_uses_rs1), .s0_uses_rs2(s0_uses_rs2), .s0_rd(s0_rd),
    .s0_writes_rd(s0_writes_rd), .s0_is_mem(s0_is_mem), .mem_ack(mem_ack),
    .s0_enable(w2_s0_enable), .pipe_enable(w2_pipe_enable), .s1_valid(w2_s1_valid),
    .s2_valid(w2_s2_valid), .mem_req(w2_mem_req), .raw_stall_cnt(w2_raw_cnt),
    .mem_stall_cnt(w2_mem_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of in-flight instructions, index 0 = s1, 1 = s2.
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit mem;
  } m_ins_t;

  m_ins_t m_pipe[2];
  int     m_raw = 0;
  int     m_mem = 0;

  function automatic bit m_busy(input int r);
    if (r == 0) return 1'b0;
    foreach (m_pipe[i])
      if (m_pipe[i].valid && m_pipe[i].wr && m_pipe[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    return s0_valid && ((s0_uses_rs1 && m_busy(int'(s0_rs1))) ||
                        (s0_uses_rs2 && m_busy(int'(s0_rs2))));
  endfunction

  function automatic bit m_req();
    return !rst && m_pipe[1].valid && m_pipe[1].mem;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Compare all outputs against the model mid-cycle.
  task automatic model_check();
    bit frz;
    @(negedge clk);
    frz = m_req() && !mem_ack;
    check("mem_req", mem_req, m_req());
    check("pipe_enable", pipe_enable, !rst && !frz);
    check("s0_enable", s0_enable, !rst && !frz && !m_hazard());
    check("s1_valid", s1_valid, m_pipe[0].valid);
    check("s2_valid", s2_valid, m_pipe[1].valid);
    check("raw_stall_cnt", raw_stall_cnt, m_raw);
    check("mem_stall_cnt", mem_stall_cnt, m_mem);
    check("w2_raw_stall_cnt", w2_raw_cnt, sat3(m_raw));
    check("w2_mem_stall_cnt", w2_mem_cnt, sat3(m_mem));
  endtask

  task automatic model_step();
    bit hz, frz;
    hz  = m_hazard();
    frz = m_req() && !mem_ack;
    if (rst) begin
      foreach (m_pipe[i]) m_pipe[i] = '{valid: 1'b0, rd: 0, wr: 1'b0, mem: 1'b0};
      m_raw = 0;
      m_mem = 0;
    end else if (frz) begin
      if (m_mem < 65535) m_mem++;
    end else begin
      if (hz && m_raw < 65535) m_raw++;
      m_pipe[1] = m_pipe[0];
      if (s0_valid && !hz)
        m_pipe[0] = '{valid: 1'b1, rd: int'(s0_rd), wr: s0_writes_rd, mem: s0_is_mem};
      else
        m_pipe[0] = '{valid: 1'b0, rd: 0, wr: 1'b0, mem: 1'b0};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; s0_valid = 1'b0; s0_rs1 = '0; s0_rs2 = '0; s0_uses_rs1 = 1'b0;
    s0_uses_rs2 = 1'b0; s0_rd = '0; s0_writes_rd = 1'b0; s0_is_mem = 1'b0; mem_ack = 1'b0;
  endtask

  typedef struct {
    logic       rst, v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, mem, ack;
    logic       e_s0en, e_pen, e_req, e_s1v, e_s2v;
    int         e_raw, e_mem;
  } vec_t;

  function automatic vec_t mk(input logic r, v, input logic [4:0] rs1, rs2, input logic u1, u2,
                              input logic [4:0] rd, input logic wr, mem, ack,
                              input logic s0e, pe, rq, s1v, s2v, input int rc, mc);
    vec_t t;
    t.rst = r; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
    t.wr = wr; t.mem = mem; t.ack = ack; t.e_s0en = s0e; t.e_pen = pe; t.e_req = rq;
    t.e_s1v = s1v; t.e_s2v = s2v; t.e_raw = rc; t.e_mem = mc;
    return t;
  endfunction

  vec_t tbl[29];

  initial begin
    foreach (m_pipe[i]) m_pipe[i] = '{valid: 1'b0, rd: 0, wr: 1'b0, mem: 1'b0};
    // rst v rs1 rs2 u1 u2 rd wr mem ack | s0en pen req s1v s2v raw mem
    tbl[0]  = mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    tbl[1]  = mk(0,1,10,11,1,1, 1,1,0,0, 1,1,0,0,0,0,0);  // independent stream
    tbl[2]  = mk(0,1,12,13,1,1, 2,1,0,0, 1,1,0,1,0,0,0);
    tbl[3]  = mk(0,1,14,15,1,1, 3,1,0,0, 1,1,0,1,1,0,0);
    tbl[4]  = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,1,1,0,0);
    tbl[5]  = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,0,1,0,0);
    tbl[6]  = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,0,0,0,0);
    tbl[7]  = mk(0,1,10,11,1,1, 5,1,0,0, 1,1,0,0,0,0,0);  // x5 producer
    tbl[8]  = mk(0,1, 5,12,1,1, 6,1,0,0, 0,1,0,1,0,0,0);  // x5 consumer
    tbl[9]  = mk(0,1, 5,12,1,1, 6,1,0,0, 0,1,0,0,1,1,0);
    tbl[10] = mk(0,1, 5,12,1,1, 6,1,0,0, 1,1,0,0,0,2,0);
    tbl[11] = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,1,0,2,0);
    tbl[12] = mk(0,1,10,11,1,1, 0,1,0,0, 1,1,0,0,1,2,0);  // writes x0
    tbl[13] = mk(0,1,13, 0,1,1, 7,1,0,0, 1,1,0,1,0,2,0);  // reads x0
    tbl[14] = mk(0,1, 7,20,0,1, 8,1,0,0, 1,1,0,1,1,2,0);  // unused rs1 matches
    tbl[15] = mk(0,1,20, 0,1,0, 9,1,1,0, 1,1,0,1,1,2,0);  // load x9
    tbl[16] = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,1,1,2,0);
    tbl[17] = mk(0,1, 9, 0,1,0,10,1,0,0, 0,0,1,0,1,2,0);  // dependent held by freeze
    tbl[18] = mk(0,1, 9, 0,1,0,10,1,0,0, 0,0,1,0,1,2,1);
    tbl[19] = mk(0,1, 9, 0,1,0,10,1,0,0, 0,0,1,0,1,2,2);
    tbl[20] = mk(0,1, 9, 0,1,0,10,1,0,1, 0,1,1,0,1,2,3);
    tbl[21] = mk(0,1, 9, 0,1,0,10,1,0,0, 1,1,0,0,0,3,3);
    tbl[22] = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,1,0,3,3);
    tbl[23] = mk(0,1, 0, 0,0,0,11,1,1,0, 1,1,0,0,1,3,3);  // load x11
    tbl[24] = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,1,0,3,3);
    tbl[25] = mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,1,0,1,3,3);
    tbl[26] = mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,1,3,4);  // reset inside MEM_WAIT
    tbl[27] = mk(0,0, 0, 0,0,0, 0,0,0,1, 1,1,0,0,0,0,0);  // stale ack ignored
    tbl[28] = mk(0,0, 0, 0,0,0, 0,0,0,0, 1,1,0,0,0,0,0);

    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].rst; s0_valid = tbl[i].v; s0_rs1 = tbl[i].rs1; s0_rs2 = tbl[i].rs2;
      s0_uses_rs1 = tbl[i].u1; s0_uses_rs2 = tbl[i].u2; s0_rd = tbl[i].rd;
      s0_writes_rd = tbl[i].wr; s0_is_mem = tbl[i].mem; mem_ack = tbl[i].ack;
      model_check();
      check($sformatf("row%0d s0_enable", i), s0_enable, tbl[i].e_s0en);
      check($sformatf("row%0d pipe_enable", i), pipe_enable, tbl[i].e_pen);
      check($sformatf("row%0d mem_req", i), mem_req, tbl[i].e_req);
      check($sformatf("row%0d s1_valid", i), s1_valid, tbl[i].e_s1v);
      check($sformatf("row%0d s2_valid", i), s2_valid, tbl[i].e_s2v);
      check($sformatf("row%0d raw_stall_cnt", i), raw_stall_cnt, tbl[i].e_raw);
      check($sformatf("row%0d mem_stall_cnt", i), mem_stall_cnt, tbl[i].e_mem);
      model_step();
    end

    // Long memory wait: narrow counter must stick at all-ones.
    set_idle();
    s0_valid = 1'b1; s0_is_mem = 1'b1; s0_rd = 5'd12; s0_writes_rd = 1'b1;
    model_check(); model_step();
    set_idle();
    model_check(); model_step();
    repeat (6) begin
      model_check(); model_step();
    end
    mem_ack = 1'b1;
    model_check();
    check("sat w2_mem_stall_cnt", w2_mem_cnt, 3);
    check("sat mem_stall_cnt", mem_stall_cnt, 6);
    check("sat mem_req", mem_req, 1);
    model_step();
    set_idle();
    model_check(); model_step();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 79) == 0);
      s0_valid     = ($urandom_range(0, 3) != 0);
      s0_rs1       = 5'($urandom_range(0, 4));
      s0_rs2       = 5'($urandom_range(0, 4));
      s0_uses_rs1  = 1'($urandom_range(0, 1));
      s0_uses_rs2  = 1'($urandom_range(0, 1));
      s0_rd        = 5'($urandom_range(0, 4));
      s0_writes_rd = ($urandom_range(0, 3) != 0);
      s0_is_mem    = ($urandom_range(0, 3) == 0);
      mem_ack      = ($urandom_range(0, 2) == 0);
      model_check();
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencer for the s0/s1/s2 integer datapath. It keeps a two-entry scoreboard of in-flight destination registers for s1 (ALU) and s2 (memory/writeback). It detects read-after-write hazards on the s0 operand reads that feed the ALU operand-select stage, and sequences the memory handshake in s2. It drives the `clk_enable` inputs of the s0 stage and the s1/s2 stages, inserts bubbles into s1, and counts stall cycles.

## Interface
Parameters:
- `STALL_CNT_WIDTH`, 16: width of each saturating stall counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `s0_valid`  in  1  s0 holds a real instruction.
- `s0_rs1`, `s0_rs2`  in  5 each  source register indices of the s0 instruction.
- `s0_uses_rs1`, `s0_uses_rs2`  in  1 each  s0 instruction reads that source.
- `s0_rd`  in  5  destination register index of the s0 instruction.
- `s0_writes_rd`  in  1  s0 instruction writes `rd`.
- `s0_is_mem`  in  1  s0 instruction needs a memory transaction in s2.
- `mem_ack`  in  1  memory completes the current s2 transaction this cycle.
- `s0_enable`  out  1  `clk_enable` for fetch/decode/operand-select (s0) registers.
- `pipe_enable`  out  1  `clk_enable` for s1 and s2 stage registers.
- `s1_valid`, `s2_valid`  out  1 each  scoreboard entry holds a real instruction.
- `mem_req`  out  1  request memory transaction for s2 instruction.
- `raw_stall_cnt`  out  STALL_CNT_WIDTH  cycles lost to RAW hazards.
- `mem_stall_cnt`  out  STALL_CNT_WIDTH  cycles lost to memory wait.

## Operation
- Scoreboard entry (s1, s2) fields: `valid`, `rd`, `writes_rd`, `is_mem`.
- A register is pending when an entry has `valid && writes_rd` and a matching `rd` that is not 0. x0 is never pending.
- `raw_hazard = s0_valid && ((s0_uses_rs1 && s0_rs1 != 0 && pending(s0_rs1)) || (s0_uses_rs2 && s0_rs2 != 0 && pending(s0_rs2)))`. Both s1 and s2 entries are checked. There is no forwarding.
- The register file write for the s2 instruction occurs on the edge where s2 advances. It is visible to the s0 read in the next cycle.
- FSM states:
  - RUN:
    - `mem_req = s2_valid && s2_is_mem`.
    - If `mem_req && !mem_ack`, go to MEM_WAIT.
  - MEM_WAIT:
    - `mem_req = 1`.
    - Stay in MEM_WAIT until `mem_ack`, then go to RUN.
- `freeze = mem_req && !mem_ack` (combinational, either state).
- `pipe_enable = !rst && !freeze`.
- `s0_enable = !rst && !freeze && !raw_hazard`.
- On an edge with `pipe_enable`:
  - s2 ← s1.
  - s1 ← s0 fields if `s0_valid && !raw_hazard`, else a bubble (`valid = 0`).
- On an edge without `pipe_enable`, s1 and s2 hold.
- Counters:
  - `raw_stall_cnt` +1 on each cycle with `raw_hazard && !freeze`.
  - `mem_stall_cnt` +1 on each cycle with `freeze`.
  - Both saturate at all-ones; no wrap.
- Simultaneous freeze and RAW hazard: only `mem_stall_cnt` increments, and no bubble is inserted (pipeline is held).

## Timing
- Reset values:
  - `s1_valid = s2_valid = 0`, state RUN, both counters 0.
  - While `rst` is high: `s0_enable = pipe_enable = mem_req = 0`.
- Reset asserted mid-MEM_WAIT: on the next edge, the state is RUN and both entries are invalid. A later `mem_ack` is ignored.
- `s0_enable`, `pipe_enable` and `mem_req` are combinational from the registered state plus s0 inputs and `mem_ack`. Consumers sample them on the same edge.
- RAW hazard penalty:
  - Dependent instruction directly behind its producer (producer in s1): 2 stall cycles, 2 bubbles.
  - Producer in s2: 1 stall cycle.
- Memory op, `mem_ack` N cycles after `mem_req` first rises (N = 0 means same cycle):
  - `mem_req` high N+1 cycles.
  - `pipe_enable` low N cycles.
  - MEM_WAIT occupied N cycles.
- Independent instructions issue one per cycle with zero bubbles.

## Test plan
- Independent stream: ADD x1, ADD x2, ADD x3 with no dependencies → `s0_enable` stays 1; `s1_valid`/`s2_valid` are 1 on consecutive cycles; `raw_stall_cnt = 0`.
- `x5 ← ...` followed by `... ← x5` (uses_rs1) → `s0_enable` low 2 cycles; two s1 bubbles; consumer enters s1 on the 3rd edge; `raw_stall_cnt = 2`.
- x0 dependence: producer `rd = 0` with `writes_rd = 1`, consumer `rs2 = 0` → no stall.
- Load in s2 with `mem_ack` 3 cycles after the request → `mem_req` high 4 cycles; `pipe_enable` low 3 cycles; `mem_stall_cnt = 3`. A dependent instruction in s0 is held and `raw_stall_cnt` does not move during the freeze.
- `rst` pulsed for 1 cycle while in MEM_WAIT → next cycle: `mem_req = 0`, both valids 0, counters 0, `s0_enable = 1`.
- Set `STALL_CNT_WIDTH = 2` and hold memory off for 6 cycles → `mem_stall_cnt` stops at 3.
